// File: rtl/mult_shift_add_datapath_pkg.sv
// Shared definitions for the shift-add multiplier datapath and its controller.
// Keeping MULT_WIDTH here lets the controller's iteration count track WIDTH.
package mult_pkg;

    localparam int MULT_WIDTH = 8;

    // Resolved controller strobe, highest priority first: LOAD > ADD > SHIFT.
    typedef enum logic [1:0] {
        NONE  = 2'd0,
        LOAD  = 2'd1,
        ADD   = 2'd2,
        SHIFT = 2'd3
    } strobe_e;

    function automatic strobe_e decode_strobe(input logic load_s, input logic add_s,
                                              input logic shift_s);
        if (load_s)       return LOAD;
        else if (add_s)   return ADD;
        else if (shift_s) return SHIFT;
        else              return NONE;
    endfunction

endpackage

// File: rtl/mult_shift_add_datapath_if.sv
// Operand handshake bundle: producer (master) offers an op_a/op_b pair,
// the datapath (slave) accepts it when op_valid && op_ready.
interface mult_shift_add_datapath_if
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
);
    logic             op_valid;
    logic             op_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    modport master (output op_valid, output op_a, output op_b, input op_ready);
    modport slave  (input op_valid, input op_a, input op_b, output op_ready);
endinterface

// File: rtl/mult_shift_add_datapath_stage.sv
// One-entry operand staging buffer. A pair is held until the datapath
// consumes it with a load; a transfer in the same cycle as the consume
// refills the buffer so staged stays set.
module mult_operand_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             ready_o,
    input  logic             consume_i,
    output logic             staged_o,
    output logic [WIDTH-1:0] stage_a_o,
    output logic [WIDTH-1:0] stage_b_o
);
    logic             staged_q, staged_d;
    logic [WIDTH-1:0] stage_a_q, stage_a_d;
    logic [WIDTH-1:0] stage_b_q, stage_b_d;
    logic             xfer;

    assign ready_o   = !staged_q;
    assign xfer      = valid_i && !staged_q;
    assign staged_o  = staged_q;
    assign stage_a_o = stage_a_q;
    assign stage_b_o = stage_b_q;

    // Capture on transfer; a consume empties the buffer unless refilled this cycle.
    always_comb begin
        staged_d  = staged_q;
        stage_a_d = stage_a_q;
        stage_b_d = stage_b_q;
        if (xfer) begin
            staged_d  = 1'b1;
            stage_a_d = a_i;
            stage_b_d = b_i;
        end else if (consume_i) begin
            staged_d = 1'b0;
        end
    end

    // Buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staged_q  <= 1'b0;
            stage_a_q <= '0;
            stage_b_q <= '0;
        end else begin
            staged_q  <= staged_d;
            stage_a_q <= stage_a_d;
            stage_b_q <= stage_b_d;
        end
    end

endmodule

// File: rtl/mult_shift_add_datapath.sv
// Shift-add multiplier datapath: A/C/Q/M registers driven by controller
// strobes (load, add, shift), with a staged operand front end and a
// {A,Q} product back end.
// Optional build macro MULT_DP_HI_NZ_EN adds prod_hi_nz_o, flagging a
// completed product whose upper half is non-zero.
module mult_shift_add_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    mult_shift_add_datapath_if.slave   op_if,
    input  logic                       load_registers_i,
    input  logic                       add_i,
    input  logic                       shift_i,
    output logic                       q0_o,
    output logic [2*WIDTH-1:0]         product_o,
    output logic                       prod_valid_o,
    output logic                       err_proto_o
`ifdef MULT_DP_HI_NZ_EN
    ,
    output logic                       prod_hi_nz_o
`endif
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] a_q, a_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pv_q, pv_d;
    logic             err_q, err_d;

    logic             staged;
    logic [WIDTH-1:0] stage_a, stage_b;
    strobe_e          stb;
    logic             multi_stb;
    logic             late_stb;

    assign stb       = decode_strobe(load_registers_i, add_i, shift_i);
    assign multi_stb = (load_registers_i && add_i) || (load_registers_i && shift_i) ||
                       (add_i && shift_i);
    // Arithmetic strobes after completion would corrupt a held product.
    assign late_stb  = pv_q && ((stb == ADD) || (stb == SHIFT));

    mult_operand_stage #(.WIDTH(WIDTH)) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_i   (op_if.op_valid),
        .a_i       (op_if.op_a),
        .b_i       (op_if.op_b),
        .ready_o   (op_if.op_ready),
        .consume_i (stb == LOAD),
        .staged_o  (staged),
        .stage_a_o (stage_a),
        .stage_b_o (stage_b)
    );

    // Execute the winning strobe; record any protocol violation.
    always_comb begin
        a_d   = a_q;
        c_d   = c_q;
        q_d   = q_q;
        m_d   = m_q;
        cnt_d = cnt_q;
        pv_d  = pv_q;
        err_d = err_q || multi_stb || late_stb;
        case (stb)
            LOAD: begin
                a_d   = '0;
                c_d   = 1'b0;
                q_d   = staged ? stage_b : '0;
                m_d   = staged ? stage_a : '0;
                cnt_d = '0;
                pv_d  = 1'b0;
                if (!staged) err_d = 1'b1;
            end
            ADD: begin
                if (!pv_q) {c_d, a_d} = {1'b0, a_q} + {1'b0, m_q};
            end
            SHIFT: begin
                if (!pv_q) begin
                    {c_d, a_d, q_d} = {1'b0, c_q, a_q, q_q[WIDTH-1:1]};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) pv_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            c_q   <= 1'b0;
            q_q   <= '0;
            m_q   <= '0;
            cnt_q <= '0;
            pv_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            c_q   <= c_d;
            q_q   <= q_d;
            m_q   <= m_d;
            cnt_q <= cnt_d;
            pv_q  <= pv_d;
            err_q <= err_d;
        end
    end

    assign q0_o         = q_q[0];
    assign product_o    = {a_q, q_q};
    assign prod_valid_o = pv_q;
    assign err_proto_o  = err_q;

`ifdef MULT_DP_HI_NZ_EN
    assign prod_hi_nz_o = pv_q && (a_q != '0);
`endif

endmodule

// File: tb/tb_mult_shift_add_datapath.sv
// Bench for the shift-add multiplier datapath; the bench plays the controller.
module tb_mult_shift_add_datapath;
    import mult_pkg::*;

    localparam int W = MULT_WIDTH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_shift_add_datapath_if #(.WIDTH(W)) op_if ();

    logic           load_r, add_r, shift_r;
    logic           q0;
    logic [2*W-1:0] product;
    logic           pv, err;
`ifdef MULT_DP_HI_NZ_EN
    logic           hi_nz;
`endif

    mult_shift_add_datapath #(.WIDTH(W), .CNT_W(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .op_if            (op_if.slave),
        .load_registers_i (load_r),
        .add_i            (add_r),
        .shift_i          (shift_r),
        .q0_o             (q0),
        .product_o        (product),
        .prod_valid_o     (pv),
        .err_proto_o      (err)
`ifdef MULT_DP_HI_NZ_EN
        ,
        .prod_hi_nz_o     (hi_nz)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic l, input logic a, input logic s);
        load_r  = l;
        add_r   = a;
        shift_r = s;
        tick();
        load_r  = 1'b0;
        add_r   = 1'b0;
        shift_r = 1'b0;
    endtask

    task automatic stage_pair(input int a, input int b);
        int n = 0;
        while (!op_if.op_ready && n < 20) begin
            tick();
            n++;
        end
        chk("stage_ready", 32'(op_if.op_ready), 32'd1);
        op_if.op_valid = 1'b1;
        op_if.op_a     = W'(a);
        op_if.op_b     = W'(b);
        tick();
        op_if.op_valid = 1'b0;
        chk("staged_busy", 32'(op_if.op_ready), 32'd0);
    endtask

    // After k iterations {A,Q} holds a*(b mod 2^k) in its top W+k bits
    // followed by the not-yet-consumed multiplier bits b >> k.
    function automatic int partial(input int a, input int b, input int k);
        int pp;
        pp = a * (b % (1 << k));
        return (pp << (W - k)) | (b >> k);
    endfunction

    task automatic run_iters(input int a, input int b, input int n);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("q0_it%0d", k), 32'(q0), 32'((b >> k) & 1));
            if (((b >> k) & 1) == 1) strobe(1'b0, 1'b1, 1'b0);
            strobe(1'b0, 1'b0, 1'b1);
            chk($sformatf("prod_it%0d_%0dx%0d", k, a, b), 32'(product), 32'(partial(a, b, k + 1)));
            chk($sformatf("pv_it%0d", k), 32'(pv), (k == W - 1) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic run_mult(input int a, input int b, input logic clean);
        stage_pair(a, b);
        strobe(1'b1, 1'b0, 1'b0);
        chk("after_load", 32'(product), 32'(b));
        run_iters(a, b, W);
        chk($sformatf("final_%0dx%0d", a, b), 32'(product), 32'(a * b));
        if (clean) chk("err_clean", 32'(err), 32'd0);
`ifdef MULT_DP_HI_NZ_EN
        chk("hi_nz", 32'(hi_nz), (((a * b) >> W) != 0) ? 32'd1 : 32'd0);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_product", 32'(product), 32'd0);
        chk("rst_pv", 32'(pv), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ready", 32'(op_if.op_ready), 32'd1);
        chk("rst_q0", 32'(q0), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int ra, rb;
        load_r = 1'b0; add_r = 1'b0; shift_r = 1'b0;
        op_if.op_valid = 1'b0; op_if.op_a = '0; op_if.op_b = '0;
        #12;
        do_reset();

        // 13 x 11
        run_mult(13, 11, 1'b1);
        chk("13x11", 32'(product), 32'h008F);

        // 0xFF x 0xFF
        run_mult(255, 255, 1'b1);
        chk("ffxff", 32'(product), 32'hFE01);

        // Offer while full: ignored; load uses the original pair.
        stage_pair(7, 9);
        op_if.op_valid = 1'b1; op_if.op_a = 8'd1; op_if.op_b = 8'd1;
        tick();
        op_if.op_valid = 1'b0;
        chk("full_not_ready", 32'(op_if.op_ready), 32'd0);
        strobe(1'b1, 1'b0, 1'b0);
        chk("kept_pair_load", 32'(product), 32'd9);
        chk("ready_after_load", 32'(op_if.op_ready), 32'd1);
        run_iters(7, 9, W);
        chk("7x9", 32'(product), 32'd63);

        // Load with empty stage plus a transfer in the same cycle.
        op_if.op_valid = 1'b1; op_if.op_a = 8'd6; op_if.op_b = 8'd7;
        load_r = 1'b1;
        tick();
        op_if.op_valid = 1'b0; load_r = 1'b0;
        chk("empty_load_prod", 32'(product), 32'd0);
        chk("empty_load_pv", 32'(pv), 32'd0);
        chk("empty_load_err", 32'(err), 32'd1);
        chk("new_pair_staged", 32'(op_if.op_ready), 32'd0);
        strobe(1'b1, 1'b0, 1'b0);
        chk("new_pair_load", 32'(product), 32'd7);
        run_iters(6, 7, W);
        chk("6x7", 32'(product), 32'd42);
        do_reset();

        // Shift after completion leaves the product alone.
        run_mult(5, 6, 1'b1);
        strobe(1'b0, 1'b0, 1'b1);
        chk("late_shift_prod", 32'(product), 32'd30);
        chk("late_shift_pv", 32'(pv), 32'd1);
        chk("late_shift_err", 32'(err), 32'd1);
        do_reset();

        // Load with nothing staged.
        strobe(1'b1, 1'b0, 1'b0);
        chk("load_empty_err", 32'(err), 32'd1);
        chk("load_empty_prod", 32'(product), 32'd0);
        do_reset();

        // add and shift together: add wins.
        stage_pair(2, 3);
        strobe(1'b1, 1'b0, 1'b0);
        strobe(1'b0, 1'b1, 1'b1);
        chk("conflict_prod", 32'(product), 32'h0203);
        chk("conflict_err", 32'(err), 32'd1);
        chk("conflict_pv", 32'(pv), 32'd0);
        do_reset();

        // Reset mid-operation, then a fresh multiply.
        stage_pair(9, 10);
        strobe(1'b1, 1'b0, 1'b0);
        run_iters(9, 10, 4);
        stage_pair(4, 4);
        do_reset();
        run_mult(3, 5, 1'b1);
        chk("3x5", 32'(product), 32'h000F);

        // Random operand pairs.
        for (int i = 0; i < 8; i++) begin
            ra = int'($urandom_range(0, 255));
            rb = int'($urandom_range(0, 255));
            run_mult(ra, rb, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
